multicycle_datapath: RTL and testbench

- Multicycle successor to the single-cycle MIPS datapath.
- One shared memory port serves both instruction and data accesses, through a req/ready handshake that tolerates wait states.
- An internal controller FSM sequences each instruction over 3-5 active cycles, reusing one ALU for PC increment, branch target and execution.
- Generalised in data width, register count and reset vector. Sits between the top-level core wrapper and the unified memory.

---
 rtl/multicycle_datapath.sv | 177 +++++++++++++++++
 tb/tb_multicycle_datapath.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-subset datapath: one shared memory port, one ALU, and a
// controller FSM sequencing each instruction over 3-5 active cycles.
module multicycle_datapath #(
    parameter int               WIDTH    = 32,
    parameter int               NREGS    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             CLK,
    input  logic             reset,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    output logic [WIDTH-1:0] pc,
    output logic             retire,
    output logic             illegal
);
    localparam int RB = $clog2(NREGS);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04,
                           OP_ADDI  = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24,
                           FN_OR  = 6'h25, FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        S_START, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] pc_reg, a_reg, b_reg, alu_out_reg, mdr_reg;
    logic [31:0]      ir_reg;
    logic [WIDTH-1:0] rf_reg [NREGS];

    logic [5:0]       opcode, funct;
    logic [RB-1:0]    rs, rt, rd;
    logic [WIDTH-1:0] sign_imm, jump_target;
    logic [WIDTH-1:0] alu_a, alu_b, alu_y;
    logic             funct_ok;
    logic             wr_en;
    logic [RB-1:0]    wr_idx;
    logic [WIDTH-1:0] wr_data;
    logic             unused_bits;

    assign opcode   = ir_reg[31:26];
    assign funct    = ir_reg[5:0];
    assign rs       = ir_reg[21 +: RB];
    assign rt       = ir_reg[16 +: RB];
    assign rd       = ir_reg[11 +: RB];
    assign sign_imm = WIDTH'($signed(ir_reg[15:0]));
    assign funct_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                      (funct == FN_OR)  || (funct == FN_SLT);
    assign unused_bits = ^{ir_reg, mem_rdata};

    // Jump keeps the upper PC bits above bit 28 only when the datapath has them.
    generate
        if (WIDTH > 28) begin : g_jump_wide
            assign jump_target = {pc_reg[WIDTH-1:28], ir_reg[25:0], 2'b00};
        end else begin : g_jump_narrow
            logic [27:0] jump_low;
            assign jump_low    = {ir_reg[25:0], 2'b00};
            assign jump_target = jump_low[WIDTH-1:0];
        end
    endgenerate

    // The single shared ALU: operand selection depends on the controller state.
    always_comb begin
        alu_a = pc_reg;
        alu_b = WIDTH'(4);
        alu_y = '0;
        case (state_reg)
            S_DECODE:           alu_b = sign_imm << 2;
            S_MEMADR, S_ADDIEX: begin alu_a = a_reg; alu_b = sign_imm; end
            S_EXEC:             begin alu_a = a_reg; alu_b = b_reg; end
            default: ;
        endcase
        if (state_reg == S_EXEC) begin
            case (funct)
                FN_SUB:  alu_y = alu_a - alu_b;
                FN_AND:  alu_y = alu_a & alu_b;
                FN_OR:   alu_y = alu_a | alu_b;
                FN_SLT:  alu_y = WIDTH'($signed(alu_a) < $signed(alu_b));
                default: alu_y = alu_a + alu_b;
            endcase
        end else begin
            alu_y = alu_a + alu_b;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_reg   <= S_START;
            pc_reg      <= RESET_PC;
            ir_reg      <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            alu_out_reg <= '0;
            mdr_reg     <= '0;
        end else begin
            case (state_reg)
                S_START: state_reg <= S_FETCH;
                S_FETCH: if (mem_ready) begin
                    ir_reg    <= 32'(mem_rdata);
                    pc_reg    <= alu_y;
                    state_reg <= S_DECODE;
                end
                S_DECODE: begin
                    a_reg       <= rf_reg[rs];
                    b_reg       <= rf_reg[rt];
                    alu_out_reg <= alu_y;
                    case (opcode)
                        OP_LW, OP_SW: state_reg <= S_MEMADR;
                        OP_RTYPE:     state_reg <= funct_ok ? S_EXEC : S_FETCH;
                        OP_BEQ:       state_reg <= S_BRANCH;
                        OP_ADDI:      state_reg <= S_ADDIEX;
                        OP_J:         state_reg <= S_JUMP;
                        default:      state_reg <= S_FETCH;
                    endcase
                end
                S_MEMADR: begin
                    alu_out_reg <= alu_y;
                    state_reg   <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: if (mem_ready) begin
                    mdr_reg   <= mem_rdata;
                    state_reg <= S_MEMWB;
                end
                S_MEMWR: if (mem_ready) state_reg <= S_FETCH;
                S_EXEC, S_ADDIEX: begin
                    alu_out_reg <= alu_y;
                    state_reg   <= (state_reg == S_EXEC) ? S_ALUWB : S_ADDIWB;
                end
                S_BRANCH: begin
                    if (a_reg == b_reg) pc_reg <= alu_out_reg;
                    state_reg <= S_FETCH;
                end
                S_JUMP: begin
                    pc_reg    <= jump_target;
                    state_reg <= S_FETCH;
                end
                default: state_reg <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        wr_en   = (state_reg == S_MEMWB) || (state_reg == S_ALUWB) || (state_reg == S_ADDIWB);
        wr_idx  = (state_reg == S_ALUWB) ? rd : rt;
        wr_data = (state_reg == S_MEMWB) ? mdr_reg : alu_out_reg;
    end

    // Entry 0 is never written, so it always reads back as zero.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) rf_reg[i] <= '0;
        end else if (wr_en && (wr_idx != '0)) begin
            rf_reg[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        mem_req   = (state_reg == S_FETCH) || (state_reg == S_MEMRD) || (state_reg == S_MEMWR);
        mem_we    = (state_reg == S_MEMWR);
        mem_addr  = (state_reg == S_FETCH) ? pc_reg :
                    (state_reg == S_MEMRD || state_reg == S_MEMWR) ? alu_out_reg : '0;
        mem_wdata = (state_reg == S_MEMWR) ? b_reg : '0;
        retire    = (state_reg == S_MEMWB) || (state_reg == S_ALUWB) ||
                    (state_reg == S_ADDIWB) || (state_reg == S_BRANCH) ||
                    (state_reg == S_JUMP) || ((state_reg == S_MEMWR) && mem_ready);
        illegal   = (state_reg == S_DECODE) &&
                    !((opcode == OP_RTYPE && funct_ok) || opcode == OP_LW || opcode == OP_SW ||
                      opcode == OP_BEQ || opcode == OP_ADDI || opcode == OP_J);
        pc        = pc_reg;
    end
endmodule

// File: tb/tb_multicycle_datapath.sv
// Scoreboard bench: expected memory transactions are queued by the stimulus
// and checked by a monitor as the datapath presents them on its memory port.
module tb_multicycle_datapath;
    logic        CLK = 1'b0;
    logic        reset;
    logic        mem_req, mem_we, mem_ready, retire, illegal;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

    multicycle_datapath #(.WIDTH(32), .NREGS(32), .RESET_PC(32'h100)) dut (
        .CLK(CLK), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .pc(pc), .retire(retire), .illegal(illegal)
    );

    always #5 CLK = ~CLK;

    typedef struct packed { logic we; logic [31:0] addr; logic [31:0] data; } txn_t;
    txn_t        exp_q[$];
    logic [31:0] mem [logic [31:0]];
    int          stall_tab [logic [31:0]];
    int          checks = 0, failures = 0;
    int          phase = 0, cyc = 0, retire_cnt = 0, illegal_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    task automatic exp_f(input logic [31:0] a);
        exp_q.push_back('{we: 1'b0, addr: a, data: 32'h0});
    endtask
    task automatic exp_w(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back('{we: 1'b1, addr: a, data: d});
    endtask

    // Memory responder: wait states come from a per-address stall budget.
    initial begin
        mem_ready = 1'b1;
        mem_rdata = '0;
        forever begin
            @(negedge CLK);
            if (reset && mem_req) begin
                if (stall_tab.exists(mem_addr) && stall_tab[mem_addr] > 0) begin
                    stall_tab[mem_addr] = stall_tab[mem_addr] - 1;
                    mem_ready = 1'b0;
                end else begin
                    mem_ready = 1'b1;
                    mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
                    if (mem_we) mem[mem_addr] = mem_wdata;
                end
            end else begin
                mem_ready = 1'b1;
            end
        end
    end

    // Monitor: scoreboard pops, handshake stability, retire timing.
    initial begin
        txn_t        e;
        logic        in_req = 1'b0;
        int          hold = 0;
        logic [31:0] lat_addr, lat_wdata;
        logic        lat_we;
        forever begin
            @(negedge CLK);
            #2;
            if (!reset) begin
                cyc    = 0;
                in_req = 1'b0;
            end else begin
                if (phase == 1 && cyc == 0) check("start_no_req", {31'b0, mem_req}, 32'h0);
                if (phase == 1 && cyc == 1) begin
                    check("first_fetch_req", {31'b0, mem_req}, 32'h1);
                    check("first_fetch_addr", mem_addr, 32'h100);
                end
                if (mem_req) begin
                    if (!in_req) begin
                        lat_addr = mem_addr; lat_we = mem_we; lat_wdata = mem_wdata;
                        hold = 0; in_req = 1'b1;
                    end else begin
                        check("hold_addr", mem_addr, lat_addr);
                        check("hold_we", {31'b0, mem_we}, {31'b0, lat_we});
                        check("hold_wdata", mem_wdata, lat_wdata);
                    end
                    hold++;
                    if (mem_ready) begin
                        in_req = 1'b0;
                        if (exp_q.size() == 0) begin
                            check("unexpected_txn_addr", mem_addr, 32'hFFFF_FFFF);
                        end else begin
                            e = exp_q.pop_front();
                            $display("txn we=%0b addr=0x%08h wdata=0x%08h cyc=%0d",
                                     mem_we, mem_addr, mem_wdata, cyc);
                            check("txn_we", {31'b0, mem_we}, {31'b0, e.we});
                            check("txn_addr", mem_addr, e.addr);
                            if (e.we) check("txn_wdata", mem_wdata, e.data);
                            if (mem_we && mem_addr == 32'h8) check("sw_wait_hold_cycles", hold, 4);
                        end
                    end
                end else begin
                    in_req = 1'b0;
                end
                if (retire) begin
                    if (phase == 1 && retire_cnt < 3)
                        check("retire_cycle", cyc, 4 * (retire_cnt + 1));
                    if (phase == 1 && retire_cnt == 2) check("pc_after_add", pc, 32'h10C);
                    retire_cnt++;
                end
                if (illegal) illegal_cnt++;
                cyc++;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},    {31'b0, mem_req}, 32'h0);
        check({tag, "_we"},     {31'b0, mem_we},  32'h0);
        check({tag, "_addr"},   mem_addr,  32'h0);
        check({tag, "_wdata"},  mem_wdata, 32'h0);
        check({tag, "_retire"}, {31'b0, retire},  32'h0);
        check({tag, "_illegal"},{31'b0, illegal}, 32'h0);
        check({tag, "_pc"},     pc, 32'h100);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge CLK);
            #3;
            n++;
        end
        check({tag, "_drain_left"}, exp_q.size(), 32'h0);
    endtask

    localparam logic [31:0] PROG [0:28] = '{
        32'h20010005, 32'h20020007, 32'h00221820, 32'hAC030008, 32'h8C040008,
        32'hAC04000C, 32'h2006FFFF, 32'h20070001, 32'h00C7282A, 32'hAC050010,
        32'h20000009, 32'hAC000014, 32'hFC000000, 32'h10220005, 32'h10210001,
        32'hAC010018, 32'h08000054, 32'h0, 32'h0, 32'h0,
        32'h00414022, 32'h00C24824, 32'h00225025, 32'hAC08001C, 32'hAC090020,
        32'hAC0A0024, 32'h0022583F, 32'hAC0B0028, 32'h1000FFFF
    };

    initial begin
        int n;
        reset = 1'b0;
        for (int i = 0; i < 29; i++) mem[32'h100 + 4 * i] = PROG[i];
        stall_tab[32'h8]   = 3;
        stall_tab[32'h150] = 2;
        repeat (3) @(negedge CLK);
        #1;
        check_reset_outputs("reset");

        // Program run: expected memory traffic in order.
        exp_f(32'h100); exp_f(32'h104); exp_f(32'h108); exp_f(32'h10C); exp_w(32'h8, 32'd12);
        exp_f(32'h110); exp_f(32'h8);   exp_f(32'h114); exp_w(32'hC, 32'd12);
        exp_f(32'h118); exp_f(32'h11C); exp_f(32'h120); exp_f(32'h124); exp_w(32'h10, 32'd1);
        exp_f(32'h128); exp_f(32'h12C); exp_w(32'h14, 32'd0);
        exp_f(32'h130); exp_f(32'h134); exp_f(32'h138); exp_f(32'h140);
        exp_f(32'h150); exp_f(32'h154); exp_f(32'h158);
        exp_f(32'h15C); exp_w(32'h1C, 32'd2); exp_f(32'h160); exp_w(32'h20, 32'd7);
        exp_f(32'h164); exp_w(32'h24, 32'd7);
        exp_f(32'h168); exp_f(32'h16C); exp_w(32'h28, 32'd0);
        exp_f(32'h170); exp_f(32'h170); exp_f(32'h170);
        phase = 1;
        @(negedge CLK);
        reset = 1'b1;
        wait_drain("prog");
        @(negedge CLK);
        reset = 1'b0;
        #1;
        check_reset_outputs("reset2");
        check("retire_count", retire_cnt, 24);
        check("illegal_count", illegal_cnt, 2);

        // Abort a load stuck in wait states.
        mem[32'h100] = 32'h8C0C0008;
        mem[32'h104] = 32'h1000FFFF;
        stall_tab[32'h8] = 20;
        exp_f(32'h100);
        phase = 2;
        @(negedge CLK);
        reset = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            #3;
            n++;
        end while (!(mem_req && !mem_we && mem_addr == 32'h8) && n < 50);
        check("memrd_reached", {31'b0, mem_req && mem_addr == 32'h8}, 32'h1);
        repeat (2) @(negedge CLK);
        reset = 1'b0;
        #1;
        check_reset_outputs("abort");
        check("abort_queue_empty", exp_q.size(), 32'h0);

        // Register 12 must read zero after the aborted load.
        mem[32'h100] = 32'hAC0C002C;
        stall_tab.delete(32'h8);
        exp_f(32'h100); exp_w(32'h2C, 32'd0); exp_f(32'h104); exp_f(32'h104);
        @(negedge CLK);
        reset = 1'b1;
        wait_drain("after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
